ifu_prefetch: RTL

Parametrised instruction-fetch unit with a small prefetch queue. It replaces the combinational fetch path with a registered PC, a valid/ready memory request channel and a FIFO of fetched {pc, inst, trap} entries. It sits between the instruction-memory port and the IF/ID stage. It supports pipeline redirect (flush) and reports fetch faults through a trap field.

---
 rtl/ifu_prefetch_pkg.sv | 10 +
 rtl/ifu_fifo.sv | 40 ++++
 rtl/ifu_prefetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: trap codes, FSM encoding and default fetch-entry layout shared by ifu_prefetch and ifu_fifo
package ifu_prefetch_pkg;
  typedef enum logic [1:0] {TRAP_NONE = 2'd0, TRAP_MISALIGN = 2'd1, TRAP_ACCESS = 2'd2} trap_e;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_e;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [1:0]  trap;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: sync FIFO (clk, rst, clear, push/wdata, pop/rdata, full/empty/count); clear and rst empty it, push allowed when full if popping
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 98
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == ($clog2(DEPTH)+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + ($clog2(DEPTH)+1)'(do_push) - ($clog2(DEPTH)+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: prefetching IFU (clk/rst, redirect_*, mem_req_*/mem_resp_*, out_* to IF/ID; IFU_PERF_CNT_EN adds perf_fetch_o/perf_flush_o/perf_stall_o)
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = 64'h8000_0000,
  parameter int TRAP_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  input  logic                mem_resp_valid_i,
  input  logic [INST_LEN-1:0] mem_resp_data_i,
  input  logic                mem_resp_err_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     out_pc_o,
  output logic [INST_LEN-1:0] out_inst_o,
  output logic [TRAP_W-1:0]   out_trap_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]         perf_fetch_o,
  output logic [63:0]         perf_flush_o,
  output logic [63:0]         perf_stall_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INST_LEN + TRAP_W;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic req_q, req_d, hs, mis, push, pop, full, empty;
  logic [CW-1:0] cnt, cnt_d;
  logic [INST_LEN-1:0] pinst;
  logic [TRAP_W-1:0] ptrap;
  logic [EW-1:0] rdata;
  assign hs = req_q & mem_req_ready_i;
  // pc_q only becomes misaligned through a redirect, so its low bits double as the pending-trap flag
  assign mis = |pc_q[1:0];
  assign pop = ~empty & out_ready_i & ~redirect_valid_i;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    push = 1'b0;
    pinst = '0;
    ptrap = TRAP_W'(TRAP_NONE);
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
      // a response landing in this very cycle settles the outstanding request, so no drain is needed
      state_d = (hs || ((state_q == S_WAIT || state_q == S_DRAIN) && !mem_resp_valid_i)) ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (mis && !full) begin
            push = 1'b1;
            ptrap = TRAP_W'(TRAP_MISALIGN);
            state_d = S_HALT;
          end else if (hs) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid_i) begin
            push = 1'b1;
            pinst = mem_resp_err_i ? '0 : mem_resp_data_i;
            ptrap = mem_resp_err_i ? TRAP_W'(TRAP_ACCESS) : TRAP_W'(TRAP_NONE);
            pc_d = pc_q + XLEN'(4);
            state_d = mem_resp_err_i ? S_HALT : S_REQ;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid_i) begin
            push = mis;
            ptrap = TRAP_W'(TRAP_MISALIGN);
            state_d = mis ? S_HALT : S_REQ;
          end
        end
        default: ;
      endcase
    end
    cnt_d = redirect_valid_i ? '0 : cnt + CW'(push) - CW'(pop);
    // credit check: in REQ nothing is outstanding, so room in the queue is the whole condition
    req_d = state_d == S_REQ && !(|pc_d[1:0]) && cnt_d < CW'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q <= RESET_ADDR;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_q <= req_d;
    end
  end
  ifu_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(redirect_valid_i),
    .push(push),
    .wdata({pc_q, pinst, ptrap}),
    .pop(pop),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .count(cnt)
  );
  assign mem_req_valid_o = req_q;
  assign mem_req_addr_o = pc_q;
  assign out_valid_o = ~empty;
  assign {out_pc_o, out_inst_o, out_trap_o} = empty ? '0 : rdata;
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_o <= '0;
      perf_flush_o <= '0;
      perf_stall_o <= '0;
    end else begin
      perf_fetch_o <= perf_fetch_o + 64'(hs);
      perf_flush_o <= perf_flush_o + 64'(redirect_valid_i);
      perf_stall_o <= perf_stall_o + 64'(empty && state_q != S_HALT);
    end
  end
`endif
endmodule
